header_stripper: RTL and testbench
==================================

HEADER_STRIPPER -- requirements
Module: header_stripper

Interface
REQ-001 Parameter DATA_WIDTH, default 128, width of the stream data bus in bits.
REQ-002 Parameter HEADER_SIZE, default 256, header length in bits; an integer multiple of DATA_WIDTH, at least DATA_WIDTH; elaboration error otherwise.
REQ-003 clk  input  1  clock.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data_in  avalon_st_if.slave  DATA_WIDTH  incoming packet stream: valid, ready, sop, eop, data, empty; header is at the front of the packet.
REQ-006 data_out  avalon_st_if.master  DATA_WIDTH  payload stream with the header removed.
REQ-007 header_out  output  HEADER_SIZE  last complete header captured.
REQ-008 header_valid  output  1  one-cycle pulse when header_out has been updated.
REQ-009 header_error  output  1  one-cycle pulse when a packet is truncated or resynchronised inside its header.

Function
REQ-010 HEADER_BEATS = HEADER_SIZE/DATA_WIDTH; beat counter hdr_cntr has width $clog2(HEADER_BEATS)+1.
REQ-011 States: HEADER_ST (consume header beats) and DATA_ST (forward payload).
REQ-012 Handshake: a beat transfers on a cycle with data_in.valid & data_in.ready.
REQ-013 In HEADER_ST, data_in.ready = 1 unconditionally, data_out.valid = 0, and header beats are never forwarded.
REQ-014 In HEADER_ST with hdr_cntr = 0, beats without sop are discarded; counting starts only at a beat carrying sop.
REQ-015 Header beat k (k = 0 first) is stored MSB-first into header_shadow[HEADER_SIZE-1-k*DATA_WIDTH -: DATA_WIDTH].
REQ-016 On transfer of beat HEADER_BEATS-1 without eop: header_out <= assembled header; header_valid = 1 in the next cycle; hdr_cntr <= 0; state <= DATA_ST; first_flag <= 1.
REQ-017 On transfer of beat HEADER_BEATS-1 with eop: header_out is updated and header_valid pulses as in REQ-016; state stays HEADER_ST; no payload packet is emitted; header_error = 0.
REQ-018 On eop at beat k < HEADER_BEATS-1: header_out is unchanged; header_error pulses in the next cycle; hdr_cntr <= 0; state stays HEADER_ST.
REQ-019 On sop at beat k > 0 in HEADER_ST: header_error pulses; the beat is taken as new beat 0; hdr_cntr <= 1.
REQ-020 DATA_ST is combinational pass-through with zero latency: data_out.valid = data_in.valid, data_out.data = data_in.data, data_in.ready = data_out.ready.
REQ-021 DATA_ST: data_out.sop = first_flag; first_flag clears on the first data_out transfer.
REQ-022 DATA_ST: data_out.eop = data_in.eop; data_out.empty = data_in.empty when eop is set, else 0.
REQ-023 DATA_ST: transfer with eop -> state <= HEADER_ST.
REQ-024 DATA_ST ignores data_in.sop; payload sop is generated only by first_flag.
REQ-025 header_out holds its value until the next complete header; header_valid and header_error are never high together.
REQ-026 The data_out.valid/data fields stay stable while data_out.ready is low, because data_in holds them under Avalon-ST rules.

Reset
REQ-027 While rst_n is low: state = HEADER_ST, hdr_cntr = 0, first_flag = 0, header_shadow = 0, header_out = 0, header_valid = 0, header_error = 0, data_out.valid/sop/eop = 0.
REQ-028 Reset asserted mid-packet abandons that packet without an error pulse; after release, the block waits for the next sop.

Structure
REQ-029 Package stream_hdr_pkg holds the state enum typedef hdr_state_t and the function header_beats(DATA_WIDTH, HEADER_SIZE); header_adder and header_stripper share it.
REQ-030 The block is a single module with no sub-module; the header shadow register stays inline.

Verification (DATA_WIDTH=128, HEADER_SIZE=256)
REQ-031 Packet of 5 beats: H0=0xA..A, H1=0xB..B, then P0,P1,P2 with eop and empty=4 -> header_out=={H0,H1}; header_valid pulses once; data_out carries P0(sop), P1, P2(eop, empty=4).
REQ-032 Same packet with data_out.ready held low for 3 cycles during P1 -> P1 held stable, data_in.ready=0 for those cycles, no beat lost or duplicated.
REQ-033 Packet of 1 beat with sop+eop -> header_error pulses; header_out unchanged; no data_out.valid.
REQ-034 Packet of exactly 2 beats, eop on H1 -> header_valid pulses; header_out updated; no data_out.valid; next packet is stripped correctly.
REQ-035 Beat 0 with sop, then a new sop on the next beat, then 4 more beats -> header_error pulses once; header taken from the 2nd and 3rd beats; 3 payload beats forwarded.
REQ-036 rst_n pulsed low during P1 -> outputs at their reset values; the next full packet is processed as in REQ-031.

Source files
------------

// File: rtl/stream_hdr_pkg.sv
// Types and helpers shared by the stream header blocks (stripper and adder).
package stream_hdr_pkg;

    typedef enum logic {
        HEADER_ST = 1'b0,
        DATA_ST   = 1'b1
    } hdr_state_t;

    function automatic int header_beats(input int data_width, input int header_size);
        return header_size / data_width;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST packet stream bundle; EMPTY_WIDTH covers the byte count of one beat.
interface avalon_st_if #(
    parameter int DATA_WIDTH  = 128,
    parameter int EMPTY_WIDTH = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
);
    logic                   valid;
    logic                   ready;
    logic                   sop;
    logic                   eop;
    logic [DATA_WIDTH-1:0]  data;
    logic [EMPTY_WIDTH-1:0] empty;

    modport master (output valid, sop, eop, data, empty, input ready);
    modport slave  (input valid, sop, eop, data, empty, output ready);
endinterface

// File: rtl/header_stripper.sv
// Removes a fixed-size header from the front of each packet, publishing it on
// header_out and forwarding the remaining payload with zero latency.
module header_stripper
    import stream_hdr_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int HEADER_SIZE = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    avalon_st_if.slave             data_in,
    avalon_st_if.master            data_out,
    output logic [HEADER_SIZE-1:0] header_out,
    output logic                   header_valid,
    output logic                   header_error
);

    localparam int HEADER_BEATS = header_beats(DATA_WIDTH, HEADER_SIZE);
    localparam int CNTR_W       = $clog2(HEADER_BEATS) + 1;
    localparam logic [CNTR_W-1:0] LAST_BEAT = CNTR_W'(HEADER_BEATS - 1);

    generate
        if ((HEADER_SIZE < DATA_WIDTH) || ((HEADER_SIZE % DATA_WIDTH) != 0)) begin : g_bad_cfg
            $error("header_stripper: HEADER_SIZE must be a non-zero multiple of DATA_WIDTH");
        end
    endgenerate

    hdr_state_t             state;
    hdr_state_t             state_next;
    logic [CNTR_W-1:0]      hdr_cntr;
    logic [CNTR_W-1:0]      cntr_next;
    logic [CNTR_W-1:0]      beat_idx;
    logic                   first_flag;
    logic                   first_next;
    logic [HEADER_SIZE-1:0] header_shadow;
    logic [HEADER_SIZE-1:0] shadow_next;
    logic                   header_load;
    logic                   valid_next;
    logic                   error_next;

    // A sop inside the header restarts assembly, so it always maps to beat 0.
    always_comb begin
        state_next       = state;
        cntr_next        = hdr_cntr;
        first_next       = first_flag;
        shadow_next      = header_shadow;
        header_load      = 1'b0;
        valid_next       = 1'b0;
        error_next       = 1'b0;
        beat_idx         = data_in.sop ? '0 : hdr_cntr;
        data_in.ready    = 1'b1;
        data_out.valid   = 1'b0;
        data_out.sop     = 1'b0;
        data_out.eop     = 1'b0;
        data_out.empty   = '0;
        data_out.data    = data_in.data;

        case (state)
            HEADER_ST: begin
                if (data_in.valid && (data_in.sop || (hdr_cntr != '0))) begin
                    for (int k = 0; k < HEADER_BEATS; k++) begin
                        if (beat_idx == CNTR_W'(k)) begin
                            shadow_next[HEADER_SIZE-1-k*DATA_WIDTH -: DATA_WIDTH] = data_in.data;
                        end
                    end
                    if (beat_idx == LAST_BEAT) begin
                        header_load = 1'b1;
                        valid_next  = 1'b1;
                        cntr_next   = '0;
                        if (!data_in.eop) begin
                            state_next = DATA_ST;
                            first_next = 1'b1;
                        end
                    end else if (data_in.eop) begin
                        error_next = 1'b1;
                        cntr_next  = '0;
                    end else begin
                        error_next = data_in.sop && (hdr_cntr != '0);
                        cntr_next  = beat_idx + 1'b1;
                    end
                end
            end
            DATA_ST: begin
                data_out.valid = data_in.valid;
                data_out.sop   = first_flag;
                data_out.eop   = data_in.eop;
                data_out.empty = data_in.eop ? data_in.empty : '0;
                data_in.ready  = data_out.ready;
                if (data_in.valid && data_out.ready) begin
                    first_next = 1'b0;
                    if (data_in.eop) begin
                        state_next = HEADER_ST;
                    end
                end
            end
            default: state_next = HEADER_ST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HEADER_ST;
            hdr_cntr      <= '0;
            first_flag    <= 1'b0;
            header_shadow <= '0;
            header_out    <= '0;
            header_valid  <= 1'b0;
            header_error  <= 1'b0;
        end else begin
            state         <= state_next;
            hdr_cntr      <= cntr_next;
            first_flag    <= first_next;
            header_shadow <= shadow_next;
            header_valid  <= valid_next;
            header_error  <= error_next;
            if (header_load) begin
                header_out <= shadow_next;
            end
        end
    end

endmodule

// File: tb/tb_header_stripper.sv
// Scoreboard bench for header_stripper: expected headers/payload beats are queued
// as stimulus is driven and consumed by a monitor on the falling clock edge.
module tb_header_stripper;

    localparam int DW = 128;
    localparam int HS = 256;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [3:0]    empty;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [HS-1:0] header_out;
    logic          header_valid;
    logic          header_error;

    avalon_st_if #(.DATA_WIDTH(DW)) in_if ();
    avalon_st_if #(.DATA_WIDTH(DW)) out_if ();

    header_stripper #(
        .DATA_WIDTH  (DW),
        .HEADER_SIZE (HS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (in_if),
        .data_out     (out_if),
        .header_out   (header_out),
        .header_valid (header_valid),
        .header_error (header_error)
    );

    always #5 clk = ~clk;

    beat_t         exp_payload[$];
    logic [HS-1:0] exp_header[$];
    logic [HS-1:0] cur_hdr;
    int            total = 0;
    int            bad = 0;
    int            err_count = 0;

    task automatic check_output(input string tag, input logic [HS-1:0] actual, input logic [HS-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Monitor: consumes expectations whenever the DUT produces something.
    always @(negedge clk) begin
        beat_t         e;
        logic [HS-1:0] h;
        if (rst_n === 1'b1) begin
            if (out_if.valid && out_if.ready) begin
                if (exp_payload.size() == 0) begin
                    check_output("unexp_payload", out_if.valid, 1'b0);
                end else begin
                    e = exp_payload.pop_front();
                    check_output("pay_data", out_if.data, e.data);
                    check_output("pay_sop", out_if.sop, e.sop);
                    check_output("pay_eop", out_if.eop, e.eop);
                    check_output("pay_empty", out_if.empty, e.empty);
                end
            end
            if (header_valid) begin
                check_output("hv_he_excl", header_error, 1'b0);
                if (exp_header.size() == 0) begin
                    check_output("unexp_header", header_valid, 1'b0);
                end else begin
                    h = exp_header.pop_front();
                    check_output("header_out", header_out, h);
                end
            end
            if (header_error) err_count++;
        end
    end

    task automatic apply_stimulus(input logic [DW-1:0] d, input logic s, input logic e,
                                  input logic [3:0] emp, input int stall);
        int   budget;
        logic rdy;
        in_if.data  = d;
        in_if.sop   = s;
        in_if.eop   = e;
        in_if.empty = emp;
        in_if.valid = 1'b1;
        if (stall > 0) begin
            out_if.ready = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                check_output("stall_in_ready", in_if.ready, 1'b0);
                check_output("stall_out_valid", out_if.valid, 1'b1);
                check_output("stall_data", out_if.data, d);
                @(posedge clk);
            end
            #1 out_if.ready = 1'b1;
        end
        budget = 0;
        do begin
            @(negedge clk);
            rdy = in_if.ready;
            @(posedge clk);
            budget++;
        end while (!rdy && budget < 50);
        if (!rdy) check_output("xfer_timeout", rdy, 1'b1);
        #1;
    endtask

    task automatic idle(input int n);
        in_if.valid = 1'b0;
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic s, input logic e, input logic [3:0] emp);
        beat_t b;
        b.data  = d;
        b.sop   = s;
        b.eop   = e;
        b.empty = emp;
        exp_payload.push_back(b);
    endtask

    // Two header beats then three payload beats, the last with empty=4.
    task automatic std_packet(input logic [DW-1:0] seed, input int stall_p1, input logic junk_sop);
        logic [DW-1:0] h0, h1, p0, p1, p2;
        h0 = {32{4'hA}} ^ seed;
        h1 = {32{4'hB}} ^ seed;
        p0 = {4{32'h1234_0001}} ^ seed;
        p1 = {4{32'h5678_0002}} ^ seed;
        p2 = {4{32'h9ABC_0003}} ^ seed;
        cur_hdr = {h0, h1};
        exp_header.push_back({h0, h1});
        push_beat(p0, 1'b1, 1'b0, 4'd0);
        push_beat(p1, 1'b0, 1'b0, 4'd0);
        push_beat(p2, 1'b0, 1'b1, 4'd4);
        apply_stimulus(h0, 1'b1, 1'b0, 4'd0, 0);
        apply_stimulus(h1, 1'b0, 1'b0, 4'd0, 0);
        apply_stimulus(p0, 1'b0, 1'b0, 4'd7, 0);
        apply_stimulus(p1, junk_sop, 1'b0, 4'd7, stall_p1);
        apply_stimulus(p2, 1'b0, 1'b1, 4'd4, 0);
    endtask

    task automatic end_test(input string name, input int exp_errs);
        idle(4);
        check_output({name, "_payload_left"}, exp_payload.size(), 0);
        check_output({name, "_header_left"}, exp_header.size(), 0);
        check_output({name, "_errors"}, err_count, exp_errs);
        err_count = 0;
    endtask

    initial begin
        rst_n        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.sop    = 1'b0;
        in_if.eop    = 1'b0;
        in_if.data   = '0;
        in_if.empty  = '0;
        out_if.ready = 1'b1;
        cur_hdr      = '0;
        #7;
        check_output("rst_header_out", header_out, '0);
        check_output("rst_header_valid", header_valid, 1'b0);
        check_output("rst_out_valid", out_if.valid, 1'b0);
        check_output("rst_in_ready", in_if.ready, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        $display("[TB] basic packet");
        std_packet('0, 0, 1'b0);
        end_test("basic", 0);

        $display("[TB] backpressure during P1");
        std_packet({4{32'h0F0F_0F0F}}, 3, 1'b0);
        end_test("stall", 0);

        $display("[TB] single beat sop+eop");
        apply_stimulus({4{32'hDEAD_BEEF}}, 1'b1, 1'b1, 4'd0, 0);
        idle(2);
        check_output("trunc_header_kept", header_out, cur_hdr);
        end_test("trunc", 1);

        $display("[TB] header-only packet, stray beat first");
        apply_stimulus({4{32'h7777_7777}}, 1'b0, 1'b0, 4'd0, 0);
        cur_hdr = {{4{32'hC0DE_0001}}, {4{32'hC0DE_0002}}};
        exp_header.push_back(cur_hdr);
        apply_stimulus({4{32'hC0DE_0001}}, 1'b1, 1'b0, 4'd0, 0);
        apply_stimulus({4{32'hC0DE_0002}}, 1'b0, 1'b1, 4'd0, 0);
        end_test("hdr_only", 0);
        std_packet({4{32'h3333_0000}}, 0, 1'b1);
        end_test("after_hdr_only", 0);

        $display("[TB] resync on second sop");
        cur_hdr = {{4{32'hBBBB_0002}}, {4{32'hCCCC_0003}}};
        exp_header.push_back(cur_hdr);
        push_beat({4{32'h0101_0101}}, 1'b1, 1'b0, 4'd0);
        push_beat({4{32'h0202_0202}}, 1'b0, 1'b0, 4'd0);
        push_beat({4{32'h0303_0303}}, 1'b0, 1'b1, 4'd2);
        apply_stimulus({4{32'hAAAA_0001}}, 1'b1, 1'b0, 4'd0, 0);
        apply_stimulus({4{32'hBBBB_0002}}, 1'b1, 1'b0, 4'd0, 0);
        apply_stimulus({4{32'hCCCC_0003}}, 1'b0, 1'b0, 4'd0, 0);
        apply_stimulus({4{32'h0101_0101}}, 1'b0, 1'b0, 4'd0, 0);
        apply_stimulus({4{32'h0202_0202}}, 1'b0, 1'b0, 4'd0, 0);
        apply_stimulus({4{32'h0303_0303}}, 1'b0, 1'b1, 4'd2, 0);
        end_test("resync", 1);

        $display("[TB] reset during P1");
        exp_header.push_back({{32{4'hA}}, {32{4'hB}}});
        push_beat({4{32'h4444_0001}}, 1'b1, 1'b0, 4'd0);
        apply_stimulus({32{4'hA}}, 1'b1, 1'b0, 4'd0, 0);
        apply_stimulus({32{4'hB}}, 1'b0, 1'b0, 4'd0, 0);
        apply_stimulus({4{32'h4444_0001}}, 1'b0, 1'b0, 4'd0, 0);
        in_if.data  = {4{32'h4444_0002}};
        in_if.sop   = 1'b0;
        in_if.eop   = 1'b0;
        in_if.valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_output("mid_rst_header_out", header_out, '0);
        check_output("mid_rst_header_valid", header_valid, 1'b0);
        check_output("mid_rst_header_error", header_error, 1'b0);
        check_output("mid_rst_out_valid", out_if.valid, 1'b0);
        check_output("mid_rst_out_sop", out_if.sop, 1'b0);
        check_output("mid_rst_out_eop", out_if.eop, 1'b0);
        @(posedge clk);
        #1 in_if.valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        std_packet({4{32'h5A5A_5A5A}}, 0, 1'b0);
        end_test("post_reset", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
